// File: rtl/vdma_wr_burst_if.sv
// AXI4 write-channel bundle (AW, W, B) between the frame burst writer and the interconnect.
interface vdma_wr_burst_if #(
    parameter int DSIZE = 256,
    parameter int ASIZE = 32
);
    logic               awvalid;
    logic               awready;
    logic [ASIZE-1:0]   awaddr;
    logic [7:0]         awlen;
    logic [2:0]         awsize;
    logic [1:0]         awburst;
    logic               wvalid;
    logic               wready;
    logic [DSIZE-1:0]   wdata;
    logic [DSIZE/8-1:0] wstrb;
    logic               wlast;
    logic               bvalid;
    logic               bready;
    logic [1:0]         bresp;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/vdma_wr_burst.sv
// Video DMA write burster: buffers packed pixel words in a FIFO and writes them
// to memory as AXI4 INCR bursts, flushing short bursts at line ends and never
// letting a burst cross a 4 KB page. One burst is outstanding at a time.
module vdma_wr_burst #(
    parameter int DSIZE     = 256,
    parameter int ASIZE     = 32,
    parameter int BURST_LEN = 16,
    parameter int DEPTH     = 64
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [ASIZE-1:0] base_addr,
    input  logic             ifs,
    input  logic             iwr_en,
    input  logic [DSIZE-1:0] idata,
    input  logic             ilast_en,
    vdma_wr_burst_if.master  axi,
    output logic             overflow,
    output logic             resp_err,
    output logic             ifs_err,
    output logic             busy
);
    localparam int BYTES     = DSIZE / 8;
    localparam int SIZE_LOG2 = $clog2(BYTES);
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int LEN_W     = 9;

    typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

    state_t           state_q, state_d;
    logic [DSIZE-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [ASIZE-1:0] addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beats_left_q, beats_left_d;
    logic             overflow_q, overflow_d;
    logic             resp_err_q, resp_err_d;
    logic             ifs_err_q, ifs_err_d;

    logic             push, pop, aw_hs, w_done, b_hs, ifs_ok;
    logic [15:0]      want_len, page_beats, idle_len;

    assign pop    = (state_q == W) && axi.wready;
    assign push   = iwr_en && ((count_q < CNT_W'(DEPTH)) || pop);
    assign aw_hs  = (state_q == AW) && axi.awready;
    assign w_done = pop && (beats_left_q == LEN_W'(1));
    assign b_hs   = (state_q == B) && axi.bvalid;
    assign ifs_ok = (state_q == IDLE) && (count_q == '0);

    // Burst sizing: a full burst when enough data is queued, otherwise flush up to the last line end, clipped to the page.
    always_comb begin
        want_len = '0;
        if (count_q >= CNT_W'(BURST_LEN)) begin
            want_len = 16'(BURST_LEN);
        end else begin
            want_len = 16'(flush_cnt_q);
        end
        page_beats = (16'd4096 - {4'd0, addr_q[11:0]}) >> SIZE_LOG2;
        idle_len   = (want_len < page_beats) ? want_len : page_beats;
    end

    // Next values for the FIFO bookkeeping, address walker and sticky status flags.
    // flush_cnt excludes words already committed to the in-flight burst, so a line end
    // arriving mid-burst never makes the next flush ask for more words than remain.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        len_d = len_q;
        if (state_q == IDLE) begin
            len_d = LEN_W'(idle_len);
        end

        beats_left_d = beats_left_q;
        if (aw_hs) begin
            beats_left_d = len_q;
        end else if (pop) begin
            beats_left_d = beats_left_q - LEN_W'(1);
        end

        flush_cnt_d = flush_cnt_q;
        if (aw_hs) begin
            flush_cnt_d = (16'(flush_cnt_q) > 16'(len_q)) ? (flush_cnt_q - CNT_W'(len_q)) : '0;
        end
        if (push && ilast_en) begin
            flush_cnt_d = count_d - CNT_W'(beats_left_d);
        end

        addr_d = addr_q;
        if (aw_hs) begin
            addr_d = addr_q + (ASIZE'(len_q) << SIZE_LOG2);
        end else if (ifs && ifs_ok) begin
            addr_d = base_addr;
        end

        overflow_d = overflow_q | (iwr_en & ~push);
        resp_err_d = resp_err_q | (b_hs && (axi.bresp != 2'b00));
        ifs_err_d  = ifs && !ifs_ok;
    end

    // Bookkeeping registers; on reset the FIFO is emptied by clearing its pointers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            flush_cnt_q  <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            beats_left_q <= '0;
            overflow_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            ifs_err_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            flush_cnt_q  <= flush_cnt_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            beats_left_q <= beats_left_d;
            overflow_q   <= overflow_d;
            resp_err_q   <= resp_err_d;
            ifs_err_q    <= ifs_err_d;
        end
    end

    // FIFO storage, written on every accepted push.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= idata;
        end
    end

    // State register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: address phase, data phase, then wait for the write response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (idle_len != '0) state_d = AW;
            AW:      if (aw_hs)          state_d = W;
            W:       if (w_done)         state_d = B;
            B:       if (b_hs)           state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state; payloads are zero outside their phase.
    always_comb begin
        axi.awvalid = (state_q == AW);
        axi.awaddr  = '0;
        axi.awlen   = '0;
        if (state_q == AW) begin
            axi.awaddr = addr_q;
            axi.awlen  = 8'(len_q - LEN_W'(1));
        end
        axi.awsize  = 3'(SIZE_LOG2);
        axi.awburst = 2'b01;
        axi.wvalid  = (state_q == W);
        axi.wdata   = (state_q == W) ? fifo_mem[rd_ptr_q] : '0;
        axi.wstrb   = (state_q == W) ? '1 : '0;
        axi.wlast   = (state_q == W) && (beats_left_q == LEN_W'(1));
        axi.bready  = (state_q == B);
        busy        = (state_q != IDLE);
        overflow    = overflow_q;
        resp_err    = resp_err_q;
        ifs_err     = ifs_err_q;
    end
endmodule

// File: tb/tb_vdma_wr_burst.sv
// Testbench for vdma_wr_burst: directed frame/line scenarios, a queue-based
// reference model compared on every falling edge, and literal burst expectations.
module tb_vdma_wr_burst;
    localparam int DSIZE     = 256;
    localparam int ASIZE     = 32;
    localparam int BURST_LEN = 16;
    localparam int DEPTH     = 64;
    localparam int BYTES     = DSIZE / 8;

    logic             clock = 1'b0;
    logic             rst;
    logic [ASIZE-1:0] base_addr;
    logic             ifs;
    logic             iwr_en;
    logic [DSIZE-1:0] idata;
    logic             ilast_en;
    logic             overflow;
    logic             resp_err;
    logic             ifs_err;
    logic             busy;

    vdma_wr_burst_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus ();

    vdma_wr_burst #(
        .DSIZE(DSIZE), .ASIZE(ASIZE), .BURST_LEN(BURST_LEN), .DEPTH(DEPTH)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .base_addr(base_addr),
        .ifs      (ifs),
        .iwr_en   (iwr_en),
        .idata    (idata),
        .ilast_en (ilast_en),
        .axi      (bus),
        .overflow (overflow),
        .resp_err (resp_err),
        .ifs_err  (ifs_err),
        .busy     (busy)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [DSIZE-1:0] data;
        logic             last;
    } word_t;
    typedef enum logic [1:0] {M_IDLE, M_AW, M_W, M_B} mphase_t;

    word_t            pend_q[$];
    logic [DSIZE-1:0] burst_q[$];
    mphase_t          m_phase;
    int               m_len;
    logic [31:0]      m_addr;
    logic             m_ovf, m_rerr, m_ifs_err;

    logic [31:0]      aw_addr_log[$];
    int               aw_len_log[$];
    logic [DSIZE-1:0] w_data_log[$];
    int               wlast_log[$];
    int               w_beats;
    logic [31:0]      next_tag;

    int               tot;
    int               l_now;
    logic             pop_now;
    word_t            w_new;

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One input cycle: optionally push a tagged word, mark a line end, or pulse ifs.
    task automatic applyStimulus(input logic wr, input logic last, input logic fs);
        iwr_en   = wr;
        ilast_en = last;
        ifs      = fs;
        if (wr) begin
            next_tag = next_tag + 32'd1;
            idata    = {8{next_tag}};
        end
        @(posedge clock);
        #1;
        iwr_en   = 1'b0;
        ilast_en = 1'b0;
        ifs      = 1'b0;
    endtask

    task automatic pushWords(input int n, input logic last_on_final);
        for (int i = 1; i <= n; i++) applyStimulus(1'b1, last_on_final && (i == n), 1'b0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic clearLogs();
        aw_addr_log.delete();
        aw_len_log.delete();
        w_data_log.delete();
        wlast_log.delete();
        w_beats = 0;
    endtask

    // Wait until the model holds no data and no burst is in flight, with a cycle budget.
    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while ((m_phase != M_IDLE || pend_q.size() != 0 || burst_q.size() != 0) && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput(name, 256'(n < budget), 256'(1));
    endtask

    // Burst length the rules demand from the queued, not-yet-committed words.
    function automatic int modelLen();
        int fl, n, lim;
        fl = 0;
        for (int i = 0; i < pend_q.size(); i++) if (pend_q[i].last) fl = i + 1;
        n   = (pend_q.size() >= BURST_LEN) ? BURST_LEN : fl;
        lim = (4096 - int'(m_addr[11:0])) / BYTES;
        return (n < lim) ? n : lim;
    endfunction

    // Reference model: check outputs against the model each falling edge, then advance
    // the model by what the coming rising edge will do with the inputs now applied.
    always @(negedge clock) begin
        if (rst) begin
            pend_q.delete();
            burst_q.delete();
            m_phase   = M_IDLE;
            m_len     = 0;
            m_addr    = '0;
            m_ovf     = 1'b0;
            m_rerr    = 1'b0;
            m_ifs_err = 1'b0;
            checkOutput("rst_awvalid", 256'(bus.awvalid), 256'(0));
            checkOutput("rst_awaddr", 256'(bus.awaddr), 256'(0));
            checkOutput("rst_awlen", 256'(bus.awlen), 256'(0));
            checkOutput("rst_awsize", 256'(bus.awsize), 256'(5));
            checkOutput("rst_awburst", 256'(bus.awburst), 256'(1));
            checkOutput("rst_wvalid", 256'(bus.wvalid), 256'(0));
            checkOutput("rst_wdata", 256'(bus.wdata), 256'(0));
            checkOutput("rst_wstrb", 256'(bus.wstrb), 256'(0));
            checkOutput("rst_wlast", 256'(bus.wlast), 256'(0));
            checkOutput("rst_bready", 256'(bus.bready), 256'(0));
            checkOutput("rst_busy", 256'(busy), 256'(0));
            checkOutput("rst_overflow", 256'(overflow), 256'(0));
            checkOutput("rst_resp_err", 256'(resp_err), 256'(0));
            checkOutput("rst_ifs_err", 256'(ifs_err), 256'(0));
        end else begin
            checkOutput("awvalid", 256'(bus.awvalid), 256'(m_phase == M_AW));
            checkOutput("wvalid", 256'(bus.wvalid), 256'(m_phase == M_W));
            checkOutput("bready", 256'(bus.bready), 256'(m_phase == M_B));
            checkOutput("busy", 256'(busy), 256'(m_phase != M_IDLE));
            checkOutput("overflow", 256'(overflow), 256'(m_ovf));
            checkOutput("resp_err", 256'(resp_err), 256'(m_rerr));
            checkOutput("ifs_err", 256'(ifs_err), 256'(m_ifs_err));
            checkOutput("awsize", 256'(bus.awsize), 256'(5));
            checkOutput("awburst", 256'(bus.awburst), 256'(1));
            if (m_phase == M_AW) begin
                checkOutput("awaddr", 256'(bus.awaddr), 256'(m_addr));
                checkOutput("awlen", 256'(bus.awlen), 256'(m_len - 1));
            end
            if (m_phase == M_W && burst_q.size() != 0) begin
                checkOutput("wdata", 256'(bus.wdata), 256'(burst_q[0]));
                checkOutput("wlast", 256'(bus.wlast), 256'(burst_q.size() == 1));
                checkOutput("wstrb", 256'(bus.wstrb), 256'(32'hFFFF_FFFF));
            end

            if (bus.awvalid && bus.awready) begin
                aw_addr_log.push_back(bus.awaddr);
                aw_len_log.push_back(int'(bus.awlen));
            end
            if (bus.wvalid && bus.wready) begin
                w_beats++;
                w_data_log.push_back(bus.wdata);
                if (bus.wlast) wlast_log.push_back(w_beats);
            end

            tot       = pend_q.size() + burst_q.size();
            pop_now   = (m_phase == M_W) && bus.wready;
            m_ifs_err = ifs && !(m_phase == M_IDLE && tot == 0);
            case (m_phase)
                M_IDLE: begin
                    l_now = modelLen();
                    if (l_now > 0) begin
                        m_len   = l_now;
                        m_phase = M_AW;
                    end
                    if (ifs && tot == 0) m_addr = base_addr;
                end
                M_AW: if (bus.awready) begin
                    for (int i = 0; i < m_len; i++) if (pend_q.size() != 0) burst_q.push_back(pend_q.pop_front().data);
                    m_addr  = m_addr + 32'(m_len * BYTES);
                    m_phase = M_W;
                end
                M_W: if (bus.wready && burst_q.size() != 0) begin
                    void'(burst_q.pop_front());
                    if (burst_q.size() == 0) m_phase = M_B;
                end
                default: if (bus.bvalid) begin
                    if (bus.bresp != 2'b00) m_rerr = 1'b1;
                    m_phase = M_IDLE;
                end
            endcase
            if (iwr_en) begin
                if (tot < DEPTH || pop_now) begin
                    w_new.data = idata;
                    w_new.last = ilast_en;
                    pend_q.push_back(w_new);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    // Directed scenarios with literal expectations for the burst sequences.
    initial begin
        logic [31:0] first_tag;
        rst         = 1'b1;
        base_addr   = '0;
        ifs         = 1'b0;
        iwr_en      = 1'b0;
        idata       = '0;
        ilast_en    = 1'b0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'b00;
        next_tag    = '0;
        clearLogs();
        repeat (2) @(posedge clock);
        #1 rst = 1'b0;

        $display("[TB] two full bursts from 0x1000");
        bus.awready = 1'b1;
        bus.wready  = 1'b1;
        bus.bvalid  = 1'b1;
        base_addr   = 32'h1000;
        applyStimulus(1'b0, 1'b0, 1'b1);
        clearLogs();
        pushWords(32, 1'b0);
        waitDrain("t1_drain", 400);
        checkOutput("t1_bursts", 256'(aw_addr_log.size()), 256'(2));
        checkOutput("t1_addr0", 256'(aw_addr_log[0]), 256'(32'h1000));
        checkOutput("t1_addr1", 256'(aw_addr_log[1]), 256'(32'h1200));
        checkOutput("t1_len0", 256'(aw_len_log[0]), 256'(15));
        checkOutput("t1_len1", 256'(aw_len_log[1]), 256'(15));
        checkOutput("t1_wlast0", 256'(wlast_log[0]), 256'(16));
        checkOutput("t1_wlast1", 256'(wlast_log[1]), 256'(32));

        $display("[TB] line end flushes a short burst");
        applyStimulus(1'b0, 1'b0, 1'b1);
        clearLogs();
        pushWords(20, 1'b1);
        waitDrain("t2_drain", 400);
        checkOutput("t2_len0", 256'(aw_len_log[0]), 256'(15));
        checkOutput("t2_addr1", 256'(aw_addr_log[1]), 256'(32'h1200));
        checkOutput("t2_len1", 256'(aw_len_log[1]), 256'(3));
        pushWords(3, 1'b0);
        idleCycles(20);
        checkOutput("t2_no_stray_flush", 256'(aw_addr_log.size()), 256'(2));
        pushWords(1, 1'b1);
        waitDrain("t2b_drain", 400);
        checkOutput("t2_addr2", 256'(aw_addr_log[2]), 256'(32'h1280));
        checkOutput("t2_len2", 256'(aw_len_log[2]), 256'(3));

        $display("[TB] 4 KB page split");
        base_addr = 32'h1F80;
        applyStimulus(1'b0, 1'b0, 1'b1);
        clearLogs();
        pushWords(16, 1'b1);
        waitDrain("t3_drain", 400);
        checkOutput("t3_addr0", 256'(aw_addr_log[0]), 256'(32'h1F80));
        checkOutput("t3_len0", 256'(aw_len_log[0]), 256'(3));
        checkOutput("t3_addr1", 256'(aw_addr_log[1]), 256'(32'h2000));
        checkOutput("t3_len1", 256'(aw_len_log[1]), 256'(11));

        $display("[TB] FIFO full with W stalled");
        base_addr  = 32'h0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        clearLogs();
        bus.wready = 1'b0;
        first_tag  = next_tag + 32'd1;
        for (int i = 1; i <= 70; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            if (i == 64) checkOutput("t4_ovf_at_64", 256'(overflow), 256'(0));
            if (i == 65) checkOutput("t4_ovf_at_65", 256'(overflow), 256'(1));
        end
        bus.wready = 1'b1;
        waitDrain("t4_drain", 600);
        checkOutput("t4_beats", 256'(w_data_log.size()), 256'(64));
        for (int j = 0; j < 64; j++) checkOutput("t4_order", 256'(w_data_log[j]), 256'({8{first_tag + 32'(j)}}));
        checkOutput("t4_bursts", 256'(aw_addr_log.size()), 256'(4));
        checkOutput("t4_ovf_sticky", 256'(overflow), 256'(1));

        $display("[TB] slave error and illegal frame start");
        base_addr = 32'h3000;
        applyStimulus(1'b0, 1'b0, 1'b1);
        clearLogs();
        bus.bresp = 2'b10;
        pushWords(16, 1'b0);
        waitDrain("t5_drain", 400);
        bus.bresp = 2'b00;
        checkOutput("t5_resp_err", 256'(resp_err), 256'(1));
        pushWords(16, 1'b0);
        waitDrain("t5b_drain", 400);
        checkOutput("t5_resp_err_sticky", 256'(resp_err), 256'(1));
        pushWords(3, 1'b0);
        base_addr = 32'h8000;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t5_ifs_err_pulse", 256'(ifs_err), 256'(1));
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t5_ifs_err_clear", 256'(ifs_err), 256'(0));
        pushWords(13, 1'b0);
        waitDrain("t5c_drain", 400);
        checkOutput("t5_addr_kept", 256'(aw_addr_log[2]), 256'(32'h3400));

        $display("[TB] reset in the middle of a data phase");
        clearLogs();
        pushWords(16, 1'b0);
        begin
            int n;
            n = 0;
            while (w_beats < 5 && n < 100) begin
                @(posedge clock);
                #1;
                n++;
            end
            checkOutput("t6_reach_beat5", 256'(n < 100), 256'(1));
        end
        rst = 1'b1;
        #1;
        checkOutput("t6_busy", 256'(busy), 256'(0));
        checkOutput("t6_wvalid", 256'(bus.wvalid), 256'(0));
        checkOutput("t6_resp_err", 256'(resp_err), 256'(0));
        repeat (2) @(posedge clock);
        #1 rst = 1'b0;
        clearLogs();
        first_tag = next_tag + 32'd1;
        pushWords(16, 1'b0);
        waitDrain("t6_drain", 400);
        checkOutput("t6_bursts", 256'(aw_addr_log.size()), 256'(1));
        checkOutput("t6_addr0", 256'(aw_addr_log[0]), 256'(0));
        checkOutput("t6_first_data", 256'(w_data_log[0]), 256'({8{first_tag}}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
